// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS link-test transmit/receive path.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PATTERN,
    ST_PRBS,
    ST_DONE
  } tx_state_e;

  localparam int BYTE_W = 8;
  localparam int LFSR_W = 15;
  localparam int REP_W  = 8;
  localparam int LEN_W  = 16;

  // PRBS-15, x^15 + x^14 + 1: feedback taps on lfsr[14] and lfsr[13]
  localparam int PRBS_TAP_HI = 14;
  localparam int PRBS_TAP_LO = 13;

  // Sync word shared with the receive-side pattern detector
  localparam logic [31:0] DEFAULT_PATTERN = 32'hAABBCCDD;

  // Sync-word byte for a given index, MSB byte first
  function automatic logic [BYTE_W-1:0] pattern_byte(input logic [31:0] pat,
                                                     input logic [1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = pat[31:24];
      2'd1:    b = pat[23:16];
      2'd2:    b = pat[15:8];
      default: b = pat[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prbs_pattern_tx_prbs15_byte_step.sv
// Eight PRBS-15 steps in one combinational slice: the output byte (first
// step in bit 7) and the LFSR state after the eighth step. Also used by
// the receive-side PRBS checker.
module prbs15_byte_step
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic [LFSR_W-1:0] lfsr_out
);

  logic [LFSR_W-1:0] s;
  logic              fb;

  // Unrolled shift: each step's feedback bit is both the new LFSR LSB and the next output bit
  always_comb begin
    s        = lfsr_in;
    fb       = 1'b0;
    byte_out = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      fb       = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
      byte_out = {byte_out[BYTE_W-2:0], fb};
      s        = {s[LFSR_W-2:0], fb};
    end
    lfsr_out = s;
  end

endmodule

// File: rtl/prbs_pattern_tx.sv
// PRBS link-test transmitter: n copies of a 32-bit sync word, then
// prbs_len PRBS-15 bytes, over a valid/ready byte stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; out_valid=0, busy=0
// ST_PATTERN | sending sync-word bytes, index 0..3, repeat 0..n-1
// ST_PRBS    | sending PRBS bytes from the registered LFSR
// ST_DONE    | done pulse for one cycle, then back to idle
module prbs_pattern_tx
  import prbs_pkg::*;
#(
  parameter logic [31:0]       PATTERN   = DEFAULT_PATTERN,
  parameter logic [LFSR_W-1:0] PRBS_SEED = 15'h7FFF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic [REP_W-1:0]  n,
  input  logic [LEN_W-1:0]  prbs_len,
  output logic [BYTE_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  tx_state_e         state;
  logic [REP_W-1:0]  n_q;
  logic [LEN_W-1:0]  len_q;
  logic [LFSR_W-1:0] lfsr;
  logic [1:0]        idx;
  logic [REP_W-1:0]  rep_cnt;
  logic [LEN_W-1:0]  byte_cnt;
  logic [BYTE_W-1:0] out_hold;

  logic [BYTE_W-1:0] prbs_byte;
  logic [LFSR_W-1:0] lfsr_next;

  logic hs;
  logic last_pattern;
  logic last_prbs;

  prbs15_byte_step u_step (
    .lfsr_in  (lfsr),
    .byte_out (prbs_byte),
    .lfsr_out (lfsr_next)
  );

  assign hs           = out_valid & out_ready;
  assign last_pattern = (idx == 2'd3) && (rep_cnt == n_q - 8'd1);
  assign last_prbs    = (byte_cnt == len_q - 16'd1);

  // Byte mux: live data while streaming, otherwise the last byte sent
  always_comb begin
    case (state)
      ST_PATTERN: out = pattern_byte(PATTERN, idx);
      ST_PRBS:    out = prbs_byte;
      default:    out = out_hold;
    endcase
  end

  // Remember the last presented byte so out does not glitch when idle
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      out_hold <= '0;
    end else if (out_valid) begin
      out_hold <= out;
    end
  end

  // Frame sequencer with registered out_valid/busy/done
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      n_q       <= '0;
      len_q     <= '0;
      lfsr      <= PRBS_SEED;
      idx       <= '0;
      rep_cnt   <= '0;
      byte_cnt  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q      <= n;
            len_q    <= prbs_len;
            lfsr     <= PRBS_SEED;
            idx      <= '0;
            rep_cnt  <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            if (n != '0) begin
              state     <= ST_PATTERN;
              out_valid <= 1'b1;
            end else if (prbs_len != '0) begin
              state     <= ST_PRBS;
              out_valid <= 1'b1;
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_PATTERN: begin
          if (hs) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              rep_cnt <= rep_cnt + 8'd1;
            end
            if (last_pattern) begin
              if (len_q != '0) begin
                state <= ST_PRBS;
              end else begin
                state     <= ST_DONE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end
          end
        end

        ST_PRBS: begin
          if (hs) begin
            lfsr     <= lfsr_next;
            byte_cnt <= byte_cnt + 16'd1;
            if (last_prbs) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // An empty frame enters here straight from idle with done still low,
          // so it spends one extra cycle raising the pulse.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_pattern_tx.sv
// Scoreboard bench for prbs_pattern_tx.
module tb_prbs_pattern_tx;

  localparam logic [31:0] PAT  = 32'hAABBCCDD;
  localparam logic [14:0] SEED = 15'h7FFF;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n = '0;
  logic [15:0] prbs_len = '0;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [14:0] ref_lfsr;

  logic [31:0] det_win;
  int          det_since;
  int          det_occ;
  logic        det_hit;

  prbs_pattern_tx #(.PATTERN(PAT), .PRBS_SEED(SEED)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .start     (start),
    .n         (n),
    .prbs_len  (prbs_len),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ref_next_byte();
    logic [7:0] r;
    logic       fb;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      fb       = ref_lfsr[14] ^ ref_lfsr[13];
      r        = {r[6:0], fb};
      ref_lfsr = {ref_lfsr[13:0], fb};
    end
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] nn, input logic [15:0] ll);
    logic [31:0] w;
    for (int r = 0; r < int'(nn); r++) begin
      w = PAT;
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[31:24]);
        w = w << 8;
      end
    end
    ref_lfsr = SEED;
    for (int k = 0; k < int'(ll); k++) exp_q.push_back(ref_next_byte());
  endtask

  // Receive-side detector stand-in: counts back-to-back sync words
  task automatic det_feed(input logic [7:0] b);
    det_win = {det_win[23:0], b};
    det_since++;
    if (det_win == PAT) begin
      det_occ   = (det_since == 4) ? det_occ + 1 : 1;
      det_since = 0;
      if (det_occ >= 4) det_hit = 1'b1;
    end
  endtask

  // One frame: mode 0 = out_ready held high, mode 1 = ready pattern 1,0,0.
  // restart_at >= 0 re-pulses start on that cycle with different lengths.
  // Returns when done is visible (DUT is then in its done cycle).
  task automatic run_stream(input logic [7:0] nn, input logic [15:0] ll, input int mode,
                            input int restart_at, output int cyc_done, output int valid_cycles);
    int         cyc;
    int         budget;
    bit         seen;
    bit         stalled;
    logic [7:0] held;
    logic [7:0] e;
    @(posedge CLK); #1;
    exp_q.delete();
    push_frame(nn, ll);
    det_win = '0; det_since = 0; det_occ = 0; det_hit = 1'b0;
    budget = 12 * int'(nn) + 3 * int'(ll) + 20;
    cyc_done = -1; valid_cycles = 0; seen = 0; stalled = 0; held = '0;
    n = nn; prbs_len = ll; start = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      start = (cyc == restart_at);
      if (cyc == restart_at) begin n = 8'd7; prbs_len = 16'd9; end
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start actual=%b required=1", busy); end
      end
      if (done === 1'b1) begin
        seen = 1; cyc_done = cyc;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          failures++; $display("FAIL done_flags busy=%b out_valid=%b required 0,0", busy, out_valid);
        end
        checks++;
        if (exp_q.size() != 0) begin
          failures++; $display("FAIL bytes_missing actual_left=%0d required=0", exp_q.size());
        end
      end else begin
        if (stalled) begin
          checks++;
          if (out_valid !== 1'b1 || out !== held) begin
            failures++; $display("FAIL stall_hold out=%h valid=%b required=%h valid=1", out, out_valid, held);
          end
        end
        out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
        stalled = 0;
        if (out_valid === 1'b1) begin
          valid_cycles++;
          if (out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL extra_byte actual=%h required=none", out);
            end else begin
              e = exp_q.pop_front();
              if (out !== e) begin failures++; $display("FAIL byte actual=%h required=%h", out, e); end
              det_feed(out);
            end
          end else begin
            stalled = 1; held = out;
          end
        end
      end
      if (!seen) begin
        @(posedge CLK); #1;
        cyc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values out=%h valid=%b busy=%b done=%b required 00,0,0,0", out, out_valid, busy, done);
    end
    RSTn = 1'b1;
  endtask

  task automatic test_basic();
    int c, v;
    run_stream(8'd2, 16'd2, 0, -1, c, v);
    checks++;
    if (c != 10) begin failures++; $display("FAIL basic_done_cycle actual=%0d required=10", c); end
    checks++;
    if (v != 10) begin failures++; $display("FAIL basic_valid_cycles actual=%0d required=10", v); end
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_width done=%b busy=%b required 0,0", done, busy);
    end
  endtask

  task automatic test_stall();
    int c, v;
    run_stream(8'd2, 16'd2, 1, -1, c, v);
    checks++;
    if (v <= 10) begin failures++; $display("FAIL stall_valid_cycles actual=%0d required=>10", v); end
  endtask

  task automatic test_short_frames();
    int c, v;
    run_stream(8'd0, 16'd3, 0, -1, c, v);
    checks++;
    if (c != 3) begin failures++; $display("FAIL prbs_only_done_cycle actual=%0d required=3", c); end
    run_stream(8'd1, 16'd0, 0, -1, c, v);
    checks++;
    if (c != 4) begin failures++; $display("FAIL pattern_only_done_cycle actual=%0d required=4", c); end
    run_stream(8'd0, 16'd0, 0, -1, c, v);
    checks++;
    if (c != 1) begin failures++; $display("FAIL empty_done_cycle actual=%0d required=1", c); end
    checks++;
    if (v != 0) begin failures++; $display("FAIL empty_valid_cycles actual=%0d required=0", v); end
  endtask

  task automatic test_ignore_start();
    int c, v;
    run_stream(8'd2, 16'd2, 0, 2, c, v);
    checks++;
    if (c != 10) begin failures++; $display("FAIL restart_done_cycle actual=%0d required=10", c); end
    n = 8'd1; prbs_len = 16'd0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL start_in_done busy=%b out_valid=%b required 0,0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int c, v, bad;
    @(posedge CLK); #1;
    n = 8'd0; prbs_len = 16'd20; out_ready = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RSTn = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset out=%h valid=%b busy=%b done=%b required 00,0,0,0", out, out_valid, busy, done);
    end
    RSTn = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (done !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL aborted_frame_activity actual=%0d required=0", bad); end
    run_stream(8'd0, 16'd2, 0, -1, c, v);
    checks++;
    if (c != 2) begin failures++; $display("FAIL replay_done_cycle actual=%0d required=2", c); end
  endtask

  task automatic test_loopback();
    int c, v;
    run_stream(8'd4, 16'd1000, 0, -1, c, v);
    checks++;
    if (det_hit !== 1'b1) begin failures++; $display("FAIL pattern_detected actual=%b required=1", det_hit); end
    checks++;
    if (c != 1016) begin failures++; $display("FAIL loopback_done_cycle actual=%0d required=1016", c); end
  endtask

  task automatic test_max_repeat();
    int c, v;
    run_stream(8'd255, 16'd1, 0, -1, c, v);
    checks++;
    if (c != 1021) begin failures++; $display("FAIL max_repeat_done_cycle actual=%0d required=1021", c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_short_frames();
    test_ignore_start();
    test_reset_mid();
    test_loopback();
    test_max_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
